// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> main-memory line swap protocol.
// The cache's swap FSM imports the same state encoding and sizing helper.
package mem_if_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GNT  = 2'd2
  } mem_stat_t;

  function automatic int line_size(input int line_addr_len);
    return 1 << line_addr_len;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Whole-line storage: synchronous line write, registered line read, both enable-gated.
// No reset; the read register holds its value between read enables.
module line_ram
  import mem_if_pkg::*;
#(
  parameter  int LINE_ADDR_LEN = 3,
  parameter  int ADDR_LEN      = 9,
  localparam int LINE_SIZE     = line_size(LINE_ADDR_LEN)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic [WORD_W-1:0]   i_wdat [LINE_SIZE],
  output logic [WORD_W-1:0]   o_rdat [LINE_SIZE]
);

  logic [WORD_W-1:0] r_mem [2**ADDR_LEN][LINE_SIZE];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdat;
    if (i_re) o_rdat <= r_mem[i_addr];
  end

endmodule

// File: rtl/line_mem_responder.sv
// Line-granular memory responder: accepts one read/write line request, waits LATENCY
// cycles, performs the access and pulses gnt. Requests are only sampled in IDLE.
module line_mem_responder
  import mem_if_pkg::*;
#(
  parameter  int LINE_ADDR_LEN = 3,
  parameter  int ADDR_LEN      = 9,
  parameter  int LATENCY       = 4,
  localparam int LINE_SIZE     = line_size(LINE_ADDR_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [WORD_W-1:0]   wr_line [LINE_SIZE],
  output logic [WORD_W-1:0]   rd_line [LINE_SIZE],
  output logic                gnt
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_stat_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_op_wr;
  logic [ADDR_LEN-1:0] r_addr;
  logic [WORD_W-1:0]   r_wdat [LINE_SIZE];
  logic                r_rd_vld;
  logic                w_accept;
  logic                w_commit;
  logic [WORD_W-1:0]   w_ram_q [LINE_SIZE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit && !r_op_wr) r_rd_vld <= 1'b1;
    end
  end

  // Request latches only matter while BUSY, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= addr;
      r_op_wr <= wr_req;
      if (wr_req) r_wdat <= wr_line;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        if (rd_req || wr_req) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = GNT;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      GNT:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  line_ram #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .ADDR_LEN     (ADDR_LEN)
  ) u_line_ram (
    .clk   (clk),
    .i_we  (w_commit && r_op_wr),
    .i_re  (w_commit && !r_op_wr),
    .i_addr(r_addr),
    .i_wdat(r_wdat),
    .o_rdat(w_ram_q)
  );

  // The RAM read register has no reset; mask it until the first read after reset.
  always_comb begin
    for (int i = 0; i < LINE_SIZE; i++) begin
      rd_line[i] = r_rd_vld ? w_ram_q[i] : '0;
    end
  end

  assign gnt = (r_state == GNT);

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: directed table, reset corner cases and random traffic
// checked against a line-array model of the memory.
module tb_line_mem_responder;

  localparam int LAL = 3;
  localparam int AL  = 9;
  localparam int LAT = 4;
  localparam int LS  = 8;

  typedef logic [LS*32-1:0] line_t;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [8:0]  a;
    logic [31:0] base;
    bit          corrupt;
    bit          drop;
    logic [31:0] exp_base;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AL-1:0] addr = '0;
  logic          rd_req = 1'b0;
  logic          wr_req = 1'b0;
  logic [31:0]   wr_line [LS];
  logic [31:0]   rd_line [LS];
  logic          gnt;

  int    n_chk = 0;
  int    n_fail = 0;
  line_t m_mem [2**AL];
  line_t m_rd;
  vec_t  tbl [17];

  line_mem_responder #(
    .LINE_ADDR_LEN(LAL),
    .ADDR_LEN     (AL),
    .LATENCY      (LAT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .wr_line(wr_line),
    .rd_line(rd_line),
    .gnt    (gnt)
  );

  always #5 clk = ~clk;

  function automatic line_t pat(input logic [31:0] base);
    line_t l;
    for (int i = 0; i < LS; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // A zero base in the table stands for the all-zero line seen after reset.
  function automatic line_t exp_line(input logic [31:0] base);
    return (base == 32'h0) ? '0 : pat(base);
  endfunction

  function automatic line_t cur_rd();
    line_t l;
    for (int i = 0; i < LS; i++) l[i*32 +: 32] = rd_line[i];
    return l;
  endfunction

  function automatic line_t rnd_line();
    line_t l;
    for (int i = 0; i < LS; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic chk(input string nm, input line_t act, input line_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one transaction from an IDLE negedge; the following posedge is E0.
  task automatic txn(input bit wr, input bit rd, input logic [AL-1:0] a, input line_t d,
                     input bit corrupt, input bit drop, input line_t exp);
    int lat;
    lat = 0;
    addr   = a;
    wr_req = wr;
    rd_req = rd;
    for (int i = 0; i < LS; i++) wr_line[i] = d[i*32 +: 32];
    for (int c = 1; c <= LAT + 6 && lat == 0; c++) begin
      @(negedge clk);
      if (gnt) begin
        lat = c;
      end else begin
        if (drop && c == 1) begin
          wr_req = 1'b0;
          rd_req = 1'b0;
        end
        if (corrupt && c == 3) begin
          addr = a + 9'd1;
          for (int i = 0; i < LS; i++) wr_line[i] = 32'h0000_DEAD;
        end
      end
    end
    chk("gnt_latency", line_t'(lat), line_t'(LAT + 1));
    chk("rd_line_at_gnt", cur_rd(), exp);
    wr_req = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    chk("gnt_one_cycle", line_t'(gnt), '0);
    chk("rd_line_hold", cur_rd(), exp);
    if (wr) m_mem[a] = d;
    else if (rd) m_rd = m_mem[a];
  endtask

  initial begin
    int    lat;
    int    g;
    bit    w;
    logic [AL-1:0] ra;
    line_t rd_l;

    for (int i = 0; i < LS; i++) wr_line[i] = '0;
    m_rd = '0;

    // Reset held with a pending read: no grant, zero line; accepted right after release.
    rd_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", line_t'(gnt), '0);
    chk("rst_rd_line", cur_rd(), '0);
    rst_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= LAT + 6 && lat == 0; c++) begin
      @(negedge clk);
      if (gnt) lat = c;
    end
    chk("rst_release_latency", line_t'(lat), line_t'(LAT + 1));
    rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_clears_rd_line", cur_rd(), '0);
    chk("rst_clears_gnt", line_t'(gnt), '0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rd = '0;

    tbl[0]  = '{1, 0, 9'h0A5, 32'h0A50_0000, 0, 0, 32'h0};
    tbl[1]  = '{1, 0, 9'h011, 32'h0110_0000, 0, 0, 32'h0};
    tbl[2]  = '{1, 0, 9'h020, 32'h2020_0000, 0, 0, 32'h0};
    tbl[3]  = '{1, 0, 9'h005, 32'h0000_1000, 0, 0, 32'h0};
    tbl[4]  = '{0, 1, 9'h005, 32'h0,         0, 0, 32'h0000_1000};
    tbl[5]  = '{1, 0, 9'h0A3, 32'hA3A3_0000, 0, 0, 32'h0000_1000};
    tbl[6]  = '{0, 1, 9'h0A5, 32'h0,         0, 0, 32'h0A50_0000};
    tbl[7]  = '{0, 1, 9'h0A3, 32'h0,         0, 0, 32'hA3A3_0000};
    tbl[8]  = '{1, 0, 9'h010, 32'hCAFE_0000, 1, 0, 32'hA3A3_0000};
    tbl[9]  = '{0, 1, 9'h010, 32'h0,         0, 0, 32'hCAFE_0000};
    tbl[10] = '{0, 1, 9'h011, 32'h0,         0, 0, 32'h0110_0000};
    tbl[11] = '{0, 1, 9'h005, 32'h0,         0, 0, 32'h0000_1000};
    tbl[12] = '{1, 0, 9'h006, 32'h0000_6000, 0, 0, 32'h0000_1000};
    tbl[13] = '{1, 1, 9'h007, 32'h0000_7000, 0, 0, 32'h0000_1000};
    tbl[14] = '{0, 1, 9'h007, 32'h0,         0, 0, 32'h0000_7000};
    tbl[15] = '{1, 0, 9'h008, 32'h0000_8000, 0, 1, 32'h0000_7000};
    tbl[16] = '{0, 1, 9'h008, 32'h0,         0, 0, 32'h0000_8000};

    for (int k = 0; k < 17; k++) begin
      txn(tbl[k].wr, tbl[k].rd, tbl[k].a, pat(tbl[k].base), tbl[k].corrupt, tbl[k].drop,
          exp_line(tbl[k].exp_base));
    end

    // Reset just after E2 of a write to 0x020: no grant, array keeps the old line.
    addr   = 9'h020;
    wr_req = 1'b1;
    for (int i = 0; i < LS; i++) wr_line[i] = 32'hBAD0_0000 + 32'(i);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    wr_req = 1'b0;
    g = 0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (gnt) g++;
    end
    chk("rst_midwrite_no_gnt", line_t'(g), '0);
    chk("rst_midwrite_rd_line", cur_rd(), '0);
    rst_n = 1'b1;
    m_rd  = '0;
    @(negedge clk);
    txn(0, 1, 9'h020, '0, 0, 0, pat(32'h2020_0000));

    // Random traffic over a pre-written address window, checked against the model.
    for (int k = 0; k < 16; k++) begin
      txn(1, 0, 9'h100 + 9'(k), rnd_line(), 0, 0, m_rd);
    end
    for (int k = 0; k < 40; k++) begin
      w    = 1'($urandom_range(0, 1));
      ra   = 9'h100 + 9'($urandom_range(0, 15));
      rd_l = w ? m_rd : m_mem[ra];
      txn(w, !w, ra, rnd_line(), 0, ($urandom_range(0, 3) == 0), rd_l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
